// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - Opcode encodings (4-bit controlBits values).
//   - FSM state encoding used by alu_seq and exposed on its debug port.
//   - Small opcode classification helpers.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_SLTU = 4'd3;
  localparam logic [3:0] OP_MUL  = 4'd4;
  localparam logic [3:0] OP_DIV  = 4'd5;
  localparam logic [3:0] OP_MOD  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_AND  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Ops that go through the multi-cycle multiply/divide unit.
  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

  // Opcodes 10..15 are undefined.
  function automatic logic is_legal_op(input logic [3:0] op);
    return op <= OP_SLT;
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// alu_iter_muldiv: iterative unsigned shift-add multiplier / restoring divider.
//   Works on magnitudes only; the caller applies signs afterwards.
// Ports:
//   clock, resetN      : clock, asynchronous active-low reset
//   start              : one-cycle pulse, samples is_div/a_mag/b_mag
//   is_div             : 1 = divide a_mag by b_mag, 0 = multiply
//   a_mag, b_mag       : unsigned operand magnitudes
//   done               : high for one cycle once the result registers are final
//   prod_hi            : upper WIDTH bits of the product (lower bits on quot)
//   quot               : quotient (divide) or low product half (multiply)
//   rem                : remainder (divide)
// The first step is taken on the start edge itself, so WIDTH steps complete
// over the start edge plus WIDTH-1 running edges; done rises while the
// counter holds 1 and the counter reaches 0 on the edge that consumes done.
module alu_iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  // acc is the shared accumulator: partial product high half (multiply)
  // or partial remainder (divide). q holds multiplier / dividend bits and
  // collects product-low / quotient bits as they shift through.
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] b_r;
  logic             div_r;
  logic             running;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   src_acc;
  logic [WIDTH-1:0] src_q;
  logic [WIDTH-1:0] src_b;
  logic             src_div;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   nxt_acc;
  logic [WIDTH-1:0] nxt_q;

  // One iteration step; on the start edge it runs on the fresh operands.
  always_comb begin
    src_acc = start ? '0 : acc;
    src_q   = start ? a_mag : q;
    src_b   = start ? b_mag : b_r;
    src_div = start ? is_div : div_r;
    sum     = src_acc + (src_q[0] ? {1'b0, src_b} : '0);
    shifted = {src_acc[WIDTH-1:0], src_q[WIDTH-1]};
    nxt_acc = '0;
    nxt_q   = '0;
    if (src_div) begin
      if (shifted >= {1'b0, src_b}) begin
        nxt_acc = shifted - {1'b0, src_b};
        nxt_q   = {src_q[WIDTH-2:0], 1'b1};
      end else begin
        nxt_acc = shifted;
        nxt_q   = {src_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      nxt_acc = {1'b0, sum[WIDTH:1]};
      nxt_q   = {sum[0], src_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      acc     <= '0;
      q       <= '0;
      b_r     <= '0;
      div_r   <= 1'b0;
      running <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      acc     <= nxt_acc;
      q       <= nxt_q;
      b_r     <= b_mag;
      div_r   <= is_div;
      running <= 1'b1;
      cnt     <= CNT_W'(WIDTH);
    end else if (running) begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        running <= 1'b0;
      end else begin
        acc <= nxt_acc;
        q   <= nxt_q;
      end
    end
  end

  assign done    = running && (cnt == CNT_W'(1));
  assign prod_hi = acc[WIDTH-1:0];
  assign rem     = acc[WIDTH-1:0];
  assign quot    = q;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with valid/ready handshakes on both sides.
// Ports:
//   clock, resetN                : clock, asynchronous active-low reset
//   startValid/startReady        : operation request handshake
//   controlBits, in1, in2        : opcode and signed operands, sampled on accept
//   out                          : result
//   zr, neg, cout, ovf           : zero, sign, carry/not-borrow, signed overflow
//   divByZero, illegalOp         : DIV/MOD with in2 == 0, undefined opcode
//   outValid/outReady            : result handshake
//   dbg_state                    : current FSM state
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. Once valid is raised its payload stays constant until that
// transfer; ready may be asserted independently of valid.
// Single-cycle ops go IDLE->DONE on the accept edge. MUL/DIV/MOD go through
// BUSY while alu_iter_muldiv iterates, then the sign fix-up is registered on
// the DONE entry edge. out and all flags are registered and hold until the
// next result is loaded.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             startValid,
  output logic             startReady,
  input  logic [3:0]       controlBits,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             neg,
  output logic             cout,
  output logic             ovf,
  output logic             divByZero,
  output logic             illegalOp,
  output logic             outValid,
  input  logic             outReady,
  output state_t           dbg_state
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES    = '1;

  state_t           state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic accept;
  assign accept    = startValid && startReady;
  assign dbg_state = state;

  // ---------------- single-cycle datapath (from live inputs) -------------
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH-1:0] sc_res;
  logic             sc_cout;
  logic             sc_ovf;
  logic             sc_ill;

  always_comb begin
    add_full = {1'b0, in1} + {1'b0, in2};
    // Subtract as in1 + ~in2 + 1 so the carry out is directly NOT borrow.
    sub_full = {1'b0, in1} + {1'b0, ~in2} + (WIDTH+1)'(1);
    sc_res   = '0;
    sc_cout  = 1'b0;
    sc_ovf   = 1'b0;
    sc_ill   = 1'b0;
    case (controlBits)
      OP_ADD: begin
        sc_res  = add_full[WIDTH-1:0];
        sc_cout = add_full[WIDTH];
        sc_ovf  = (in1[WIDTH-1] == in2[WIDTH-1]) &&
                  (add_full[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res  = sub_full[WIDTH-1:0];
        sc_cout = sub_full[WIDTH];
        sc_ovf  = (in1[WIDTH-1] != in2[WIDTH-1]) &&
                  (sub_full[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_XOR:  sc_res = in1 ^ in2;
      OP_OR:   sc_res = in1 | in2;
      OP_AND:  sc_res = in1 & in2;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (in1 < in2)};
      default: sc_ill = !is_legal_op(controlBits);
    endcase
  end

  // ---------------- iterative unit ----------------------------------------
  logic             it_start;
  logic             it_is_div;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             it_done;
  logic [WIDTH-1:0] it_hi;
  logic [WIDTH-1:0] it_quot;
  logic [WIDTH-1:0] it_rem;

  assign it_start  = accept && is_iter_op(controlBits);
  assign it_is_div = (controlBits != OP_MUL);
  // |MIN| is 2^(WIDTH-1), which is representable as an unsigned magnitude.
  assign a_mag     = in1[WIDTH-1] ? (~in1 + WIDTH'(1)) : in1;
  assign b_mag     = in2[WIDTH-1] ? (~in2 + WIDTH'(1)) : in2;

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
    .clock   (clock),
    .resetN  (resetN),
    .start   (it_start),
    .is_div  (it_is_div),
    .a_mag   (a_mag),
    .b_mag   (b_mag),
    .done    (it_done),
    .prod_hi (it_hi),
    .quot    (it_quot),
    .rem     (it_rem)
  );

  // ---------------- sign fix-up for MUL/DIV/MOD ---------------------------
  logic                 a_neg;
  logic                 b_neg;
  logic [2*WIDTH-1:0]   prod_mag;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]     it_res;
  logic                 it_ovf;
  logic                 it_dbz;

  always_comb begin
    a_neg    = a_q[WIDTH-1];
    b_neg    = b_q[WIDTH-1];
    prod_mag = {it_hi, it_quot};
    prod_s   = (a_neg ^ b_neg) ? (~prod_mag + (2*WIDTH)'(1)) : prod_mag;
    it_res   = '0;
    it_ovf   = 1'b0;
    it_dbz   = 1'b0;
    case (op_q)
      OP_MUL: begin
        it_res = prod_s[WIDTH-1:0];
        // Fits only if the high half is the sign extension of the low half.
        it_ovf = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});
      end
      OP_DIV: begin
        if (b_q == '0) begin
          it_res = ONES;
          it_dbz = 1'b1;
        end else if ((a_q == MIN_VAL) && (b_q == ONES)) begin
          it_res = MIN_VAL;
          it_ovf = 1'b1;
        end else begin
          it_res = (a_neg ^ b_neg) ? (~it_quot + WIDTH'(1)) : it_quot;
        end
      end
      OP_MOD: begin
        if (b_q == '0) begin
          it_res = a_q;
          it_dbz = 1'b1;
        end else begin
          // MIN % -1 falls out as a zero remainder magnitude.
          it_res = a_neg ? (~it_rem + WIDTH'(1)) : it_rem;
        end
      end
      default: it_res = '0;
    endcase
  end

  // ---------------- FSM with registered outputs ---------------------------
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state      <= S_IDLE;
      startReady <= 1'b1;
      outValid   <= 1'b0;
      out        <= '0;
      zr         <= 1'b0;
      neg        <= 1'b0;
      cout       <= 1'b0;
      ovf        <= 1'b0;
      divByZero  <= 1'b0;
      illegalOp  <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q       <= controlBits;
            a_q        <= in1;
            b_q        <= in2;
            startReady <= 1'b0;
            if (is_iter_op(controlBits)) begin
              state <= S_BUSY;
            end else begin
              state     <= S_DONE;
              outValid  <= 1'b1;
              out       <= sc_res;
              zr        <= (sc_res == '0);
              neg       <= sc_res[WIDTH-1];
              cout      <= sc_cout;
              ovf       <= sc_ovf;
              divByZero <= 1'b0;
              illegalOp <= sc_ill;
            end
          end
        end
        S_BUSY: begin
          if (it_done) begin
            state     <= S_DONE;
            outValid  <= 1'b1;
            out       <= it_res;
            zr        <= (it_res == '0);
            neg       <= it_res[WIDTH-1];
            cout      <= 1'b0;
            ovf       <= it_ovf;
            divByZero <= it_dbz;
            illegalOp <= 1'b0;
          end
        end
        S_DONE: begin
          if (outReady) begin
            state      <= S_IDLE;
            outValid   <= 1'b0;
            startReady <= 1'b1;
          end
        end
        default: begin
          state      <= S_IDLE;
          outValid   <= 1'b0;
          startReady <= 1'b1;
        end
      endcase
    end
  end

endmodule
